// File: rtl/seq_div_if.sv
// Operand/result bundle for the 32-bit sequential divider.
// Handshake: start is a one-cycle request taken only while busy=0 (IDLE); operands are
// sampled on that edge. done pulses for one cycle when quotient/remainder/div_zero update.
interface seq_div_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/seq_div.sv
// 32-bit restoring divider (signed/unsigned), one quotient bit per cycle, 33-cycle latency.
// FSM state is exported on state_dbg for checkers.
module seq_div (
  input  logic       clk,
  input  logic       rst_n,
  seq_div_if.slave   bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  cnt;
  logic [32:0] prem;
  logic [31:0] dvd_sh;
  logic [31:0] dvs_mag;
  logic [31:0] dvd_orig;
  logic [31:0] quo_acc;
  logic        q_neg;
  logic        r_neg;
  logic        dz;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] shifted;
  logic [33:0] diff;
  logic        step_ok;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes and sign bookkeeping, used only on the accept edge
  always_comb begin
    a_neg = bus.is_signed & bus.dividend[31];
    b_neg = bus.is_signed & bus.divisor[31];
    a_mag = a_neg ? (~bus.dividend + 32'd1) : bus.dividend;
    b_mag = b_neg ? (~bus.divisor + 32'd1) : bus.divisor;
  end

  // One restoring step: a borrow out of the top bit means the trial subtract went negative
  always_comb begin
    shifted = {prem, dvd_sh[31]};
    diff    = shifted - {2'b00, dvs_mag};
    step_ok = ~diff[33];
    q_fix   = q_neg ? (~quo_acc + 32'd1) : quo_acc;
    r_fix   = r_neg ? (~prem[31:0] + 32'd1) : prem[31:0];
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt == 5'd31) state_next = FIX;
      end
      FIX: begin
        bus.busy   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= 5'd0;
      prem          <= 33'd0;
      dvd_sh        <= 32'd0;
      dvs_mag       <= 32'd0;
      dvd_orig      <= 32'd0;
      quo_acc       <= 32'd0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      dz            <= 1'b0;
      bus.quotient  <= 32'd0;
      bus.remainder <= 32'd0;
      bus.div_zero  <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt      <= 5'd0;
            prem     <= 33'd0;
            dvd_sh   <= a_mag;
            dvs_mag  <= b_mag;
            dvd_orig <= bus.dividend;
            quo_acc  <= 32'd0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            dz       <= (bus.divisor == 32'd0);
          end
        end
        CALC: begin
          prem    <= step_ok ? diff[32:0] : shifted[32:0];
          dvd_sh  <= {dvd_sh[30:0], 1'b0};
          quo_acc <= {quo_acc[30:0], step_ok};
          cnt     <= cnt + 5'd1;
        end
        FIX: begin
          // A zero divisor reports all-ones and hands back the untouched dividend
          bus.quotient  <= dz ? 32'hFFFF_FFFF : q_fix;
          bus.remainder <= dz ? dvd_orig : r_fix;
          bus.div_zero  <= dz;
          bus.done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: constant vector table, model-checked random operands, and
// hand-written sequences for ignored start, back-to-back, and reset abort.
module tb_seq_div;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  seq_div_if bus ();

  seq_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [64:0] exp_q[$];   // {div_zero, quotient, remainder}

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'd0};
    if (s) begin
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sq, sr};
    end
    return {1'b0, a / b, a % b};
  endfunction

  // Monitor: every done must match the oldest pending expectation
  always @(posedge clk) begin
    #1;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("quotient", bus.quotient, e[63:32]);
        check("remainder", bus.remainder, e[31:0]);
        check("div_zero", {31'd0, bus.div_zero}, {31'd0, e[64]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [64:0] e, input bit push);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int exp_n, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
      else if (n == 1) check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    end
    check({name, "_latency"}, n, exp_n);
    if (seen) check({name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic done_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rs;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b0};
    vecs[4]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          1'b0};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,          1'b1};
    vecs[6]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,          1'b1};
    vecs[7]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,          1'b0};
    vecs[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1};
    vecs[12] = '{1'b1, 32'h8000_0000, 32'd1,          32'h8000_0000, 32'd0,          1'b0};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, each started in the previous done cycle
    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].dz, vecs[i].q, vecs[i].r}, 1'b1);
      wait_done(33, $sformatf("vec%0d", i));
    end

    // Random operands against the behavioural model
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 4 == 1) rb = {{28{rb[31]}}, rb[3:0]};
      start_op(rs, ra, rb, model(rs, ra, rb), 1'b1);
      wait_done(33, $sformatf("rnd%0d", i));
    end

    // Start while busy is ignored; start in the done cycle is accepted
    start_op(1'b0, 32'd1000, 32'd33, {1'b0, 32'd30, 32'd10}, 1'b1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(23, "ignored_start");
    check("hold_after_done_state", {30'd0, state_dbg}, 32'd0);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7, {1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE}, 1'b1);
    wait_done(33, "back_to_back");

    // Reset in the middle of an operation: aborted result never appears
    start_op(1'b0, 32'd5, 32'd0, {1'b1, 32'hFFFF_FFFF, 32'd5}, 1'b1);
    wait_done(33, "pre_abort_dz");
    start_op(1'b0, 32'd123, 32'd4, 65'd0, 1'b0);
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_quotient", bus.quotient, 32'd0);
    check("abort_remainder", bus.remainder, 32'd0);
    check("abort_div_zero", {31'd0, bus.div_zero}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
    end
    check("abort_no_done", {31'd0, done_seen}, 32'd0);

    // start coinciding with reset is dropped
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.dividend = 32'd8;
    bus.divisor  = 32'd2;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    check("start_in_reset_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    check("start_in_reset_busy", {31'd0, bus.busy}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
    end
    check("start_in_reset_no_done", {31'd0, done_seen}, 32'd0);

    check("pending_results", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
